// File: rtl/rotate_seq.sv
// rotate_seq: sequencer for an N-bit serial rotate register.
//
// The block owns the shift register and drives its 2:1 LSB feedback select.
// It loads a word serially (MSB first) or rotates the held word a programmed
// number of positions. Completion is flagged by a one-cycle done pulse.
//
// Optional feature macro: ROT_DIR_EN (adds the dir input; dir=1 rotates right).
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   command strobe, sampled only in IDLE
//   mode     in   0 = serial load, 1 = rotate (sampled with start)
//   amount   in   rotate distance (sampled with start, ignored for load)
//   in       in   serial data, MSB first, one bit per LOAD cycle
//   dir      in   (ROT_DIR_EN only) 0 = rotate left, 1 = rotate right
//   select   out  feedback select: 0 = in, 1 = recirculate
//   data_out out  register contents
//   busy     out  high in LOAD and ROT
//   done     out  one-cycle pulse in DONE
module rotate_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             in,
`ifdef ROT_DIR_EN
    input  logic             dir,
`endif
    output logic             select,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);

    // One extra bit so the counter can hold WIDTH for a full load.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ROT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_data;
    logic             r_select;
    logic             r_busy;
    logic             r_done;
`ifdef ROT_DIR_EN
    logic             r_dir;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_data   <= '0;
            r_select <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef ROT_DIR_EN
            r_dir    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
`ifdef ROT_DIR_EN
                        r_dir <= dir;
`endif
                        if (!mode) begin
                            r_count  <= CW'(WIDTH);
                            r_state  <= S_LOAD;
                            r_busy   <= 1'b1;
                            r_select <= 1'b0;
                        end else if (amount != '0) begin
                            r_count  <= {{(CW-AMT_W){1'b0}}, amount};
                            r_state  <= S_ROT;
                            r_busy   <= 1'b1;
                            r_select <= 1'b1;
                        end else begin
                            // Zero-distance rotate completes without touching data.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    r_data  <= {r_data[WIDTH-2:0], in};
                    r_count <= r_count - 1'b1;
                    if (r_count == CW'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                S_ROT: begin
`ifdef ROT_DIR_EN
                    if (r_dir)
                        r_data <= {r_data[0], r_data[WIDTH-1:1]};
                    else
                        r_data <= {r_data[WIDTH-2:0], r_data[WIDTH-1]};
`else
                    r_data <= {r_data[WIDTH-2:0], r_data[WIDTH-1]};
`endif
                    r_count <= r_count - 1'b1;
                    if (r_count == CW'(1)) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_select <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_select <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign select   = r_select;
    assign data_out = r_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
